// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch -> decode -> execute -> write-back control FSM
// for the lab CPU datapath. Every output is a register, so nothing on imem_*
// reaches an output combinationally.
// Optional retired-instruction counter (perf_cnt port): define CPU_SEQ_PERF_CNT_EN.

`ifndef INSTRUCTION_NOP
`define INSTRUCTION_NOP 16'h0000
`endif
`ifndef INSTRUCTION_AND
`define INSTRUCTION_AND 16'h0001
`endif
`ifndef INSTRUCTION_OR
`define INSTRUCTION_OR  16'h0002
`endif
`ifndef INSTRUCTION_XOR
`define INSTRUCTION_XOR 16'h0003
`endif
`ifndef INSTRUCTION_NEG
`define INSTRUCTION_NEG 16'h0004
`endif
`ifndef INSTRUCTION_ADD
`define INSTRUCTION_ADD 16'h0005
`endif
`ifndef INSTRUCTION_SUB
`define INSTRUCTION_SUB 16'h0006
`endif

module cpu_sequencer #(
    parameter int          PC_WIDTH    = 8,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_data,
    output logic [31:0]         instr,
    output logic                alu_en,
    output logic                rf_we,
    output logic [7:0]          rf_waddr,
    output logic                busy,
    output logic                halted,
    output logic                illegal
`ifdef CPU_SEQ_PERF_CNT_EN
   ,output logic [CNT_WIDTH-1:0] perf_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_e;

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [31:0]           instr_q;
    logic                  req_q, alu_q, we_q, busy_q, halted_q, illegal_q;
    logic [15:0]           opcode;
    logic                  is_alu;

    if (PC_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
        $error("cpu_sequencer: PC_WIDTH and CNT_WIDTH must be >= 1");
    end

    assign opcode = instr_q[31:16];
    assign is_alu = opcode inside {`INSTRUCTION_AND, `INSTRUCTION_OR, `INSTRUCTION_XOR,
                                   `INSTRUCTION_NEG, `INSTRUCTION_ADD, `INSTRUCTION_SUB};

    // Sequencer FSM; outputs are registered alongside the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            req_q     <= 1'b0;
            alu_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_data;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // HALT is checked first so it wins even if it aliases a mapped opcode.
                    if (opcode == HALT_OPCODE) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (opcode == `INSTRUCTION_NOP) begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end else if (is_alu) begin
                        state_q <= S_EXEC;
                        alu_q   <= 1'b1;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                        busy_q    <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_q   <= 1'b0;
                    we_q    <= 1'b1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    // PC wraps silently at 2^PC_WIDTH.
                    we_q    <= 1'b0;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_HALT: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        pc_q      <= '0;
                        illegal_q <= 1'b0;
                        halted_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        req_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    req_q    <= 1'b0;
                    alu_q    <= 1'b0;
                    we_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign alu_en    = alu_q;
    assign rf_we     = we_q;
    assign rf_waddr  = instr_q[15:8];
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 retire, start_acc;

    // A NOP retires in its DECODE cycle, an ALU op in its WB cycle.
    assign retire    = (state_q == S_WB) ||
                       (state_q == S_DECODE && opcode != HALT_OPCODE && opcode == `INSTRUCTION_NOP);
    assign start_acc = start && (state_q == S_IDLE || state_q == S_HALT);

    // Saturating retired-instruction counter, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (retire && cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign perf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer. A transaction-level model turns each
// accepted fetch into the list of cycles the instruction should occupy and
// compares every cycle's outputs against it.

`ifndef INSTRUCTION_NOP
`define INSTRUCTION_NOP 16'h0000
`endif
`ifndef INSTRUCTION_AND
`define INSTRUCTION_AND 16'h0001
`endif
`ifndef INSTRUCTION_OR
`define INSTRUCTION_OR  16'h0002
`endif
`ifndef INSTRUCTION_XOR
`define INSTRUCTION_XOR 16'h0003
`endif
`ifndef INSTRUCTION_NEG
`define INSTRUCTION_NEG 16'h0004
`endif
`ifndef INSTRUCTION_ADD
`define INSTRUCTION_ADD 16'h0005
`endif
`ifndef INSTRUCTION_SUB
`define INSTRUCTION_SUB 16'h0006
`endif

module tb_cpu_sequencer;
  localparam int PCW   = 3;
  localparam int CW    = 2;
  localparam int NMEM  = 1 << PCW;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [15:0] HALT_OP = 16'hFFFF;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic            imem_valid = 1'b0;
  logic [31:0]     imem_data = '0;
  logic            imem_req, alu_en, rf_we, busy, halted, illegal;
  logic [PCW-1:0]  imem_addr;
  logic [31:0]     instr;
  logic [7:0]      rf_waddr;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [CW-1:0]   perf_cnt;
`endif

  cpu_sequencer #(.PC_WIDTH(PCW), .HALT_OPCODE(HALT_OP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .instr(instr), .alu_en(alu_en), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .halted(halted), .illegal(illegal)
`ifdef CPU_SEQ_PERF_CNT_EN
   ,.perf_cnt(perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One expected cycle; ret = an instruction retires at the end of it.
  typedef struct packed {logic req, alu, we, busy, halted, ret;} exp_t;

  exp_t        q[$];
  logic [31:0] mem [NMEM];
  int          pass_cnt = 0, chk_cnt = 0;
  // model state
  bit          m_run, m_halt, m_ill;
  int          m_pc, m_cnt, wait_left;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t mk(logic req, logic alu, logic we, logic bsy, logic hlt, logic ret);
    exp_t e;
    e.req = req; e.alu = alu; e.we = we; e.busy = bsy; e.halted = hlt; e.ret = ret;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int r = $urandom_range(99);
    logic [15:0] op;
    if (r < 35)      op = `INSTRUCTION_NOP;
    else if (r < 88) begin
      case ($urandom_range(5))
        0: op = `INSTRUCTION_AND;
        1: op = `INSTRUCTION_OR;
        2: op = `INSTRUCTION_XOR;
        3: op = `INSTRUCTION_NEG;
        4: op = `INSTRUCTION_ADD;
        default: op = `INSTRUCTION_SUB;
      endcase
    end
    else if (r < 94) op = HALT_OP;
    else             op = 16'h0100 | 16'($urandom_range(255)); // unmapped
    return {op, 16'($urandom)};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NMEM; i++) mem[i] = rnd_instr();
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_halt = 0; m_ill = 0;
    m_pc = 0; m_cnt = 0; m_instr = '0; wait_left = 0;
  endtask

  initial begin
    exp_t cur;
    bit   from_q, is_alu;
    logic [15:0] op;
    model_reset();
    fill_mem();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      from_q = (q.size() != 0);
      if (from_q)      cur = q.pop_front();
      else if (m_run)  cur = mk(1, 0, 0, 1, 0, 0);
      else if (m_halt) cur = mk(0, 0, 0, 0, 1, 0);
      else             cur = mk(0, 0, 0, 0, 0, 0);

      chk("imem_req", 32'(imem_req), 32'(cur.req));
      chk("alu_en",   32'(alu_en),   32'(cur.alu));
      chk("rf_we",    32'(rf_we),    32'(cur.we));
      chk("busy",     32'(busy),     32'(cur.busy));
      chk("halted",   32'(halted),   32'(cur.halted));
      chk("illegal",  32'(illegal),  from_q ? 32'd0 : 32'(m_ill));
      chk("instr",    instr,         m_instr);
      if (!from_q) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (cur.we)  chk("rf_waddr",  32'(rf_waddr),  32'(m_instr[15:8]));
`ifdef CPU_SEQ_PERF_CNT_EN
      chk("perf_cnt", 32'(perf_cnt), 32'(m_cnt));
`endif
      rst_n = 1'b1;

      // Occasionally drop reset in the middle of EXEC: outputs clear at once.
      if (cur.alu && $urandom_range(15) == 0) begin
        rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0;
        #1;
        chk("rst_req",  32'(imem_req),  0);
        chk("rst_alu",  32'(alu_en),    0);
        chk("rst_we",   32'(rf_we),     0);
        chk("rst_busy", 32'(busy),      0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_inst", instr,          0);
        chk("rst_wadr", 32'(rf_waddr),  0);
`ifdef CPU_SEQ_PERF_CNT_EN
        chk("rst_perf", 32'(perf_cnt),  0);
`endif
        model_reset();
        continue;
      end

      // Drive inputs for the coming edge.
      start = cur.busy ? ($urandom_range(11) == 0) : ($urandom_range(3) == 0);
      if (cur.req) begin
        if (wait_left == 0) begin
          imem_valid = 1'b1; imem_data = mem[m_pc];
        end else begin
          wait_left--; imem_valid = 1'b0; imem_data = $urandom;
        end
      end else begin
        imem_valid = ($urandom_range(2) == 0); imem_data = $urandom;
      end

      // Model the effect of the coming edge.
      if (cur.ret && m_cnt < CMAX) m_cnt++;
      if (start && !cur.busy) begin
        q.delete();
        m_run = 1; m_halt = 0; m_ill = 0; m_pc = 0; m_cnt = 0;
        wait_left = $urandom_range(3);
        if ($urandom_range(1) == 0) fill_mem();
      end else if (cur.req && imem_valid) begin
        m_instr = imem_data;
        op = imem_data[31:16];
        is_alu = op inside {`INSTRUCTION_AND, `INSTRUCTION_OR, `INSTRUCTION_XOR,
                            `INSTRUCTION_NEG, `INSTRUCTION_ADD, `INSTRUCTION_SUB};
        if (op == HALT_OP) begin
          q.push_back(mk(0, 0, 0, 1, 0, 0));
          m_run = 0; m_halt = 1;
        end else if (op == `INSTRUCTION_NOP) begin
          q.push_back(mk(0, 0, 0, 1, 0, 1));
          m_pc = (m_pc + 1) % NMEM;
          wait_left = $urandom_range(3);
        end else if (is_alu) begin
          q.push_back(mk(0, 0, 0, 1, 0, 0));
          q.push_back(mk(0, 1, 0, 1, 0, 0));
          q.push_back(mk(0, 0, 1, 1, 0, 1));
          m_pc = (m_pc + 1) % NMEM;
          wait_left = $urandom_range(3);
        end else begin
          q.push_back(mk(0, 0, 0, 1, 0, 0));
          m_run = 0; m_halt = 1; m_ill = 1;
        end
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
